// File: rtl/foreground_prefetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : foreground_prefetch_scheduler
// Description : Turns visible line starts from the video timing generator into
//               one-cycle prefetch start pulses (with target y) for the
//               foreground object-scanline prefetch unit. Tracks the unit's
//               busy handshake, keeps at most one request pending, and counts
//               requests that had to be dropped.
// Ports       : gpu_clk, rst_n (sync, active-low)
//               enable_i, line_start_i, display_y_i[7:0]  - line requests
//               prefetch_busy_i                            - unit handshake
//               clear_stats_i                              - zero statistics
//               prefetch_start_o, prefetch_y_o[7:0]        - issue to unit
//               busy_o, drop_o, drop_count_o[7:0], timeout_o - status
// Revision    : 1.0 - initial release
// ============================================================================
module foreground_prefetch_scheduler #(
    parameter int NUM_LINES   = 240,
    parameter int LOOKAHEAD   = 1,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic       gpu_clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       line_start_i,
    input  logic [7:0] display_y_i,
    input  logic       prefetch_busy_i,
    input  logic       clear_stats_i,
    output logic       prefetch_start_o,
    output logic [7:0] prefetch_y_o,
    output logic       busy_o,
    output logic       drop_o,
    output logic [7:0] drop_count_o,
    output logic       timeout_o
);

    localparam int C_CNT_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] C_ST_IDLE      = 2'd0;
    localparam logic [1:0] C_ST_ISSUE     = 2'd1;
    localparam logic [1:0] C_ST_WAIT_ACK  = 2'd2;
    localparam logic [1:0] C_ST_WAIT_DONE = 2'd3;

    logic [1:0]         state_q,      state_d;
    logic               pend_v_q,     pend_v_d;
    logic [7:0]         pend_y_q,     pend_y_d;
    logic [C_CNT_W-1:0] cnt_q,        cnt_d;
    logic               start_q,      start_d;
    logic [7:0]         y_q,          y_d;
    logic               busy_q,       busy_d;
    logic               drop_q,       drop_d;
    logic [7:0]         drop_cnt_q,   drop_cnt_d;
    logic               timeout_q,    timeout_d;

    logic [8:0] w_sum;
    logic [7:0] w_target;
    logic       w_req;
    logic       w_pend_live;
    logic       w_issue;
    logic       w_issue_new;
    logic       w_slot_write;
    logic       w_drop;

    // Target line: add at 9 bits so y + LOOKAHEAD cannot overflow before the
    // wrap compare, then fold back into the visible range.
    always_comb begin
        w_sum = {1'b0, display_y_i} + 9'(LOOKAHEAD);
        if (w_sum >= 9'(NUM_LINES)) begin
            w_target = 8'(w_sum - 9'(NUM_LINES));
        end else begin
            w_target = 8'(w_sum);
        end
    end

    // Vblank lines (y >= NUM_LINES) are dropped here without any trace.
    assign w_req = line_start_i & enable_i & ({1'b0, display_y_i} < 9'(NUM_LINES));

    // A disabled scheduler discards its pending entry, so treat it as gone
    // in the same cycle rather than letting it issue.
    assign w_pend_live = pend_v_q & enable_i;

    assign w_issue      = (state_q == C_ST_IDLE) & ~prefetch_busy_i & (w_pend_live | w_req);
    // The new request goes straight out only when nothing is queued ahead.
    assign w_issue_new  = w_issue & ~w_pend_live;
    assign w_slot_write = w_req & ~w_issue_new;
    // Issuing the pending entry frees the slot, so the new request replacing
    // it in the same cycle is not a drop.
    assign w_drop       = w_slot_write & w_pend_live & ~w_issue;

    always_comb begin
        state_d    = state_q;
        pend_v_d   = pend_v_q;
        pend_y_d   = pend_y_q;
        cnt_d      = cnt_q;
        start_d    = 1'b0;
        y_d        = y_q;
        drop_d     = 1'b0;
        drop_cnt_d = drop_cnt_q;
        timeout_d  = timeout_q;

        case (state_q)
            C_ST_IDLE: begin
                if (w_issue) begin
                    state_d = C_ST_ISSUE;
                    start_d = 1'b1;
                    y_d     = w_pend_live ? pend_y_q : w_target;
                end
            end
            C_ST_ISSUE: begin
                state_d = C_ST_WAIT_ACK;
                cnt_d   = C_CNT_W'(ACK_TIMEOUT);
            end
            C_ST_WAIT_ACK: begin
                if (prefetch_busy_i) begin
                    state_d = C_ST_WAIT_DONE;
                end else if (cnt_q <= C_CNT_W'(1)) begin
                    // Last cycle of the ack window expired without busy.
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = C_ST_IDLE;
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end
            C_ST_WAIT_DONE: begin
                if (!prefetch_busy_i) begin
                    state_d = C_ST_IDLE;
                end
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase

        if (!enable_i) begin
            pend_v_d = 1'b0;
        end else if (w_slot_write) begin
            pend_v_d = 1'b1;
            pend_y_d = w_target;
        end else if (w_issue) begin
            pend_v_d = 1'b0;
        end

        if (w_drop) begin
            drop_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

        // Clear takes priority over a drop or timeout in the same cycle.
        if (clear_stats_i) begin
            drop_cnt_d = 8'd0;
            timeout_d  = 1'b0;
        end

        // Reflects the current (registered) state, so it trails by a cycle.
        busy_d = (state_q != C_ST_IDLE) | pend_v_q;
    end

    always_ff @(posedge gpu_clk) begin
        if (!rst_n) begin
            state_q    <= C_ST_IDLE;
            pend_v_q   <= 1'b0;
            pend_y_q   <= 8'd0;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            y_q        <= 8'd0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_v_q   <= pend_v_d;
            pend_y_q   <= pend_y_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            y_q        <= y_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign prefetch_start_o = start_q;
    assign prefetch_y_o     = y_q;
    assign busy_o           = busy_q;
    assign drop_o           = drop_q;
    assign drop_count_o     = drop_cnt_q;
    assign timeout_o        = timeout_q;

endmodule
`default_nettype wire

// File: doc/foreground_prefetch_scheduler.md
# foreground_prefetch_scheduler

Sequences the foreground object-scanline prefetch unit from video timing. On each visible line start it computes the line to prefetch, issues a one-cycle start pulse with the target y, tracks the prefetch unit's busy handshake, and holds at most one request pending while the unit is busy. It sits in the GPU between the video timing generator and the foreground block's `prefetch_start_i`/`prefetch_y_i` inputs, and keeps statistics on requests it had to drop.

## Interface
- `NUM_LINES`, default 240: number of visible lines. Valid y is 0..NUM_LINES-1.
- `LOOKAHEAD`, default 1: how many lines ahead of the current line to prefetch. Range 1..NUM_LINES-1.
- `ACK_TIMEOUT`, default 4: cycles allowed for `prefetch_busy_i` to rise after a start pulse.

Ports:
- `gpu_clk`  in  1  sole clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `enable_i`  in  1  gates acceptance of new line requests.
- `line_start_i`  in  1  one-cycle pulse at the start of each line.
- `display_y_i`  in  8  current line number; sampled when `line_start_i` is high.
- `prefetch_busy_i`  in  1  high while the foreground prefetch unit is not idle.
- `clear_stats_i`  in  1  zeroes `drop_count_o`.
- `prefetch_start_o`  out  1  one-cycle start pulse to the foreground block.
- `prefetch_y_o`  out  8  target line; held stable from the start pulse until the next issue.
- `busy_o`  out  1  high when the state is not IDLE or a request is pending.
- `drop_o`  out  1  one-cycle pulse when a pending request is overwritten.
- `drop_count_o`  out  8  saturating count of dropped requests.
- `timeout_o`  out  1  sticky; set on an ack timeout, cleared by reset or `clear_stats_i`.

## Operation
- **Request capture.** A request is accepted when `line_start_i`, `enable_i` and `display_y_i < NUM_LINES` are all high.
  - Target = `display_y_i + LOOKAHEAD`; if that is ≥ NUM_LINES, subtract NUM_LINES.
  - Compute at 9-bit width, then truncate to 8 bits.
  - Lines with y ≥ NUM_LINES (vblank) are ignored silently.
- **Pending slot.** There is one entry, `pend_v`/`pend_y`.
  - A request accepted while the slot cannot issue this cycle is written into the slot.
  - If `pend_v` is already 1, the new request overwrites it, `drop_o` pulses, and `drop_count_o` increments, saturating at 255.
- **State machine: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.**
  - **IDLE.** When a request source exists and `prefetch_busy_i`==0, go to ISSUE and latch the target into `prefetch_y_o`.
    - The request source is `pend_v` if set; otherwise the request accepted this cycle.
    - If both exist, the pending request issues and the new request goes into the slot, with no drop.
    - If the source is the pending slot, clear `pend_v`.
  - **ISSUE.** `prefetch_start_o`=1 for this cycle only. Next state is WAIT_ACK, and the timeout counter is loaded to ACK_TIMEOUT.
  - **WAIT_ACK.**
    - If `prefetch_busy_i`==1, go to WAIT_DONE.
    - Otherwise decrement the counter; at 0, set `timeout_o` and go to IDLE.
  - **WAIT_DONE.** When `prefetch_busy_i`==0, go to IDLE.
- A pending request issues from IDLE at the earliest one cycle after returning to IDLE.
- **`enable_i` low.** No new acceptance. `pend_v` is cleared without counting a drop. An in-flight sequence runs to completion.
- **`clear_stats_i`.** Zeroes `drop_count_o` and `timeout_o` next cycle. If a drop happens in the same cycle, the result is 0; the clear wins.
- **Reset values** (`rst_n`=0 at a posedge, including mid-sequence):
  - state IDLE, `pend_v`=0
  - `prefetch_start_o`=0, `prefetch_y_o`=0
  - `busy_o`=0, `drop_o`=0, `drop_count_o`=0, `timeout_o`=0
- If `prefetch_busy_i` is high out of reset, no issue occurs until it falls.

## Timing
- All outputs are registered.
- Minimum latency: `line_start_i` at cycle t in IDLE with busy low gives `prefetch_start_o` at t+1 and `prefetch_y_o` valid at t+1.
- `prefetch_start_o` never pulses in two consecutive cycles. Minimum spacing between pulses is 3 cycles (ISSUE → WAIT_ACK → IDLE → ISSUE).
- `drop_o` pulses in the cycle after the overwriting request.
- `busy_o` updates the cycle after a state or `pend_v` change.

## Test plan
- **Single request.** Reset, enable=1, line_start with y=10, busy rises at t+2 and falls at t+50 → start pulse at t+1 with y_o=11, state returns IDLE at t+51, `busy_o` low at t+52.
- **Wrap and vblank.** y=239 → y_o=0. y=245 → no pulse. LOOKAHEAD=2 with y=238 → y_o=0.
- **Pending and drop.** Busy held high, then line starts for y=20, 21, 22 → first issues y_o=21 and 22 pends. y=22 overwrites the pending entry with 23, `drop_o` pulses once, `drop_count_o`=1. After busy falls, y_o=23 issues 2 cycles later.
- **Ack timeout.** `prefetch_busy_i` tied 0 → `timeout_o` sets 5 cycles after the start pulse, and the next request still issues normally.
- **Simultaneous pending and new request.** A pending entry exists on return to IDLE and a new line start arrives in the same cycle → pending issues first, the new request pends, `drop_count_o` unchanged.
- **Reset and saturation.**
  - Reset asserted during WAIT_DONE → all outputs return to reset values next cycle.
  - With busy high, 300 forced drops → `drop_count_o` saturates at 255.
  - `clear_stats_i` → 0.
